// File: rtl/set_bit_enumerator_pkg.sv
// Shared types for the set-bit enumerator: FSM encoding and the
// derived bit-position width.
package set_bit_enumerator_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Width of a binary bit position for a word of width w.
    function automatic int index_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/set_bit_enumerator_onehot_to_binary.sv
// Combinational one-hot to binary encoder; OR-reduce of set positions,
// correct only when at most one input bit is set.
module onehot_to_binary
    import set_bit_enumerator_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int INDEX_WIDTH = index_width(WORD_WIDTH)
) (
    input  logic [WORD_WIDTH-1:0]  onehot,
    output logic [INDEX_WIDTH-1:0] index
);

    always_comb begin
        index = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (onehot[i]) index = index | INDEX_WIDTH'(i);
        end
    end

endmodule

// File: rtl/set_bit_enumerator.sv
// Serialises the set bits of a word, lowest first, one beat per bit under
// valid/ready; an all-zero word produces a single empty beat.
module set_bit_enumerator
    import set_bit_enumerator_pkg::*;
#(
    parameter  int WORD_WIDTH  = 8,
    localparam int INDEX_WIDTH = index_width(WORD_WIDTH)
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [WORD_WIDTH-1:0]  word_in,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [WORD_WIDTH-1:0]  output_onehot,
    output logic [INDEX_WIDTH-1:0] output_index,
    output logic                   output_last,
    output logic                   output_empty
);

    localparam logic [WORD_WIDTH-1:0] ONE = {{(WORD_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state, state_nx;
    logic [WORD_WIDTH-1:0]   remaining;
    logic [WORD_WIDTH-1:0]   lowest;
    logic [WORD_WIDTH-1:0]   stripped;
    logic                    accept;
    logic                    advance;

    // Rightmost-bit isolate and clear; both wrap modulo 2^WORD_WIDTH.
    assign lowest   = remaining & (~remaining + ONE);
    assign stripped = remaining & (remaining - ONE);

    assign accept  = (state == IDLE) && input_valid;
    assign advance = (state == EMIT) && output_ready;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear)        remaining <= '0;
        else if (accept)  remaining <= word_in;
        else if (advance) remaining <= stripped;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (input_valid) state_nx = EMIT;
            EMIT: if (output_ready && (stripped == '0)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        input_ready   = 1'b0;
        output_valid  = 1'b0;
        output_onehot = '0;
        output_last   = 1'b0;
        output_empty  = 1'b0;
        unique case (state)
            IDLE: input_ready = 1'b1;
            EMIT: begin
                output_valid  = 1'b1;
                output_onehot = lowest;
                output_last   = (stripped == '0);
                output_empty  = (remaining == '0);
            end
            default: ;
        endcase
    end

    onehot_to_binary #(
        .WORD_WIDTH (WORD_WIDTH),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_enc (
        .onehot(output_onehot),
        .index (output_index)
    );

endmodule

// File: tb/tb_set_bit_enumerator.sv
// Directed and random bench for set_bit_enumerator with a beat scoreboard.
module tb_set_bit_enumerator;

    localparam int W  = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic [W-1:0]  oh;
        logic [IW-1:0] idx;
        logic          last;
        logic          empty;
    } beat_t;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic          input_valid = 1'b0;
    logic          input_ready;
    logic [W-1:0]  word_in = '0;
    logic          output_valid;
    logic          output_ready = 1'b1;
    logic [W-1:0]  output_onehot;
    logic [IW-1:0] output_index;
    logic          output_last;
    logic          output_empty;

    int    n_checks = 0;
    int    n_fails  = 0;
    int    ready_mode = 0;   // 0 always, 1 toggle, 2 random
    beat_t sb[$];

    set_bit_enumerator #(.WORD_WIDTH(W)) dut (
        .clock        (clock),
        .clear        (clear),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .word_in      (word_in),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_onehot(output_onehot),
        .output_index (output_index),
        .output_last  (output_last),
        .output_empty (output_empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent model: scan bits upward, last beat is the highest set bit.
    task automatic push_expected(input logic [W-1:0] w);
        beat_t b;
        if (w == '0) begin
            b = '{oh: '0, idx: '0, last: 1'b1, empty: 1'b1};
            sb.push_back(b);
        end else begin
            for (int i = 0; i < W; i++) begin
                if (w[i]) begin
                    b.oh    = W'(1) << i;
                    b.idx   = IW'(i);
                    b.last  = ((w >> (i + 1)) == '0);
                    b.empty = 1'b0;
                    sb.push_back(b);
                end
            end
        end
    endtask

    // Output-side driver for backpressure patterns.
    always @(posedge clock) begin
        #1;
        case (ready_mode)
            1:       output_ready = ~output_ready;
            2:       output_ready = ($urandom_range(3) != 0);
            default: output_ready = 1'b1;
        endcase
    end

    // Monitor: compare accepted beats against the scoreboard, check stall stability.
    beat_t prev;
    logic  prev_stall = 1'b0;
    always @(negedge clock) begin
        beat_t cur, e;
        cur = '{oh: output_onehot, idx: output_index, last: output_last, empty: output_empty};
        if (output_valid && prev_stall)
            chk("stall_stable", 32'(cur), 32'(prev));
        if (output_valid && output_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(cur), 32'h0_DEAD);
            end else begin
                e = sb.pop_front();
                chk("beat", 32'(cur), 32'(e));
            end
        end
        prev       = cur;
        prev_stall = output_valid && !output_ready;
    end

    // Drive one word; returns one cycle after the accepting edge.
    task automatic send_word(input logic [W-1:0] w, input bit hold);
        int guard = 0;
        input_valid = 1'b1;
        word_in     = w;
        push_expected(w);
        while (!input_ready && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 200) chk("accept_timeout", 32'(guard), 32'd0);
        @(posedge clock); #1;
        if (!hold) input_valid = 1'b0;
        chk("latency1_valid", 32'(output_valid), 32'd1);
        chk("emit_not_ready", 32'(input_ready), 32'd0);
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb.size() != 0 || output_valid) && guard < 400) begin
            @(posedge clock); #1;
            guard++;
        end
        if (guard >= 400) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [W-1:0] w;
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        // Reset state
        #23;
        chk("rst_valid", 32'(output_valid), 32'd0);
        chk("rst_onehot", 32'(output_onehot), 32'd0);
        chk("rst_index", 32'(output_index), 32'd0);
        chk("rst_last", 32'(output_last), 32'd0);
        chk("rst_empty", 32'(output_empty), 32'd0);
        @(posedge clock); #1;
        clear = 1'b0;
        #1;
        chk("rst_in_ready", 32'(input_ready), 32'd1);

        // 0xA8, sink always ready: three beats then idle after popcount cycles
        ready_mode = 0;
        send_word(8'hA8, 0);
        repeat (3) @(posedge clock);
        #1;
        chk("a8_idle_ready", 32'(input_ready), 32'd1);
        chk("a8_drained", 32'(sb.size()), 32'd0);

        // Zero word: one empty beat, idle two cycles after acceptance
        send_word(8'h00, 0);
        @(posedge clock); #1;
        chk("zero_idle_ready", 32'(input_ready), 32'd1);
        chk("zero_drained", 32'(sb.size()), 32'd0);

        // 0xFF with toggling backpressure
        ready_mode = 1;
        send_word(8'hFF, 0);
        drain();

        // 0x80 with valid held through EMIT, followed by 0x03
        ready_mode = 0;
        send_word(8'h80, 1);
        send_word(8'h03, 0);
        drain();

        // Clear after two of four beats of 0x0F
        send_word(8'h0F, 0);
        repeat (2) @(posedge clock);
        #1;
        chk("abort_pending", 32'(sb.size()), 32'd2);
        clear = 1'b1;
        #1;
        chk("abort_valid", 32'(output_valid), 32'd0);
        sb.delete();
        @(negedge clock);
        clear = 1'b0;
        #1;
        chk("abort_in_ready", 32'(input_ready), 32'd1);
        @(posedge clock); #1;
        send_word(8'h5A, 0);
        drain();

        // Random words with random backpressure
        ready_mode = 2;
        for (int n = 0; n < 2000; n++) begin
            w = W'($urandom);
            if (n % 16 == 0) w = '0;
            send_word(w, 0);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
